// File: rtl/karatsuba_mult_pipe.sv
// Four-stage unsigned Karatsuba multiplier (single split level) with a
// valid/ready handshake, per-stage valid bits, tag side-band and busy flag.
module karatsuba_mult_pipe #(
  parameter int unsigned W     = 64,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned H  = W / 2;
  localparam int unsigned PW = 2 * W;

  if ((W < 4) || ((W % 2) != 0)) begin : g_w_check
    $error("karatsuba_mult_pipe: W must be even and >= 4");
  end
  if (TAG_W < 1) begin : g_tag_check
    $error("karatsuba_mult_pipe: TAG_W must be >= 1");
  end

  // Stage valid bits and stall network
  logic v1, v2, v3, v4;
  logic adv1, adv2, adv3, adv4;

  // A stage advances if it is empty or the stage ahead advances, so bubbles collapse.
  assign adv4 = !v4 || out_ready;
  assign adv3 = !v3 || adv4;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;

  assign in_ready  = adv1;
  assign out_valid = v4;
  assign busy      = v1 | v2 | v3 | v4;

  // S1: split operands and form the half sums (H+1 bits, carry kept)
  logic [H-1:0]     s1_x_hi, s1_x_lo, s1_y_hi, s1_y_lo;
  logic [H:0]       s1_sx, s1_sy;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1      <= 1'b0;
      s1_x_hi <= '0;
      s1_x_lo <= '0;
      s1_y_hi <= '0;
      s1_y_lo <= '0;
      s1_sx   <= '0;
      s1_sy   <= '0;
      s1_tag  <= '0;
    end else if (adv1) begin
      v1      <= in_valid;
      s1_x_hi <= x[W-1:H];
      s1_x_lo <= x[H-1:0];
      s1_y_hi <= y[W-1:H];
      s1_y_lo <= y[H-1:0];
      s1_sx   <= (H+1)'(x[W-1:H]) + (H+1)'(x[H-1:0]);
      s1_sy   <= (H+1)'(y[W-1:H]) + (H+1)'(y[H-1:0]);
      s1_tag  <= in_tag;
    end
  end

  // S2: the three partial products
  logic [W-1:0]     s2_p11, s2_p00;
  logic [W+1:0]     s2_p10;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v2     <= 1'b0;
      s2_p11 <= '0;
      s2_p00 <= '0;
      s2_p10 <= '0;
      s2_tag <= '0;
    end else if (adv2) begin
      v2     <= v1;
      s2_p11 <= W'(s1_x_hi) * W'(s1_y_hi);
      s2_p00 <= W'(s1_x_lo) * W'(s1_y_lo);
      s2_p10 <= (W+2)'(s1_sx) * (W+2)'(s1_sy);
      s2_tag <= s1_tag;
    end
  end

  // S3: middle term X1*Y0 + X0*Y1 is non-negative and fits in W+1 bits
  logic [W+1:0]     mid_full;
  logic [W-1:0]     s3_high, s3_low;
  logic [W:0]       s3_mid;
  logic [TAG_W-1:0] s3_tag;

  assign mid_full = s2_p10 - (W+2)'(s2_p11) - (W+2)'(s2_p00);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v3      <= 1'b0;
      s3_high <= '0;
      s3_low  <= '0;
      s3_mid  <= '0;
      s3_tag  <= '0;
    end else if (adv3) begin
      v3      <= v2;
      s3_high <= s2_p11;
      s3_low  <= s2_p00;
      s3_mid  <= (W+1)'(mid_full);
      s3_tag  <= s2_tag;
    end
  end

  // S4: recombine at full product width
  logic [PW-1:0] p_sum;

  assign p_sum = {s3_high, {W{1'b0}}} + (PW'(s3_mid) << H) + PW'(s3_low);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v4      <= 1'b0;
      p       <= '0;
      out_tag <= '0;
    end else if (adv4) begin
      v4      <= v3;
      p       <= p_sum;
      out_tag <= s3_tag;
    end
  end

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Scoreboard bench: a W=64 instance for directed cases and a W=16 instance for
// randomized traffic with random backpressure, both checked against x*y.
module tb_karatsuba_mult_pipe;

  logic clock;
  logic reset_n;

  logic         in_valid64, in_ready64, out_valid64, out_ready64, busy64;
  logic [63:0]  x64, y64;
  logic [3:0]   in_tag64, out_tag64;
  logic [127:0] p64;

  logic         in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0]  x16, y16;
  logic [3:0]   in_tag16, out_tag16;
  logic [31:0]  p16;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] q64_p[$];
  logic [3:0]   q64_t[$];
  logic [31:0]  q16_p[$];
  logic [3:0]   q16_t[$];

  karatsuba_mult_pipe #(.W(64), .TAG_W(4)) dut64 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .x(x64), .y(y64), .in_tag(in_tag64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .p(p64), .out_tag(out_tag64), .busy(busy64)
  );

  karatsuba_mult_pipe #(.W(16), .TAG_W(4)) dut16 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .x(x16), .y(y16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .p(p16), .out_tag(out_tag16), .busy(busy16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 64-bit instance: pops on each retire, checks hold stability
  logic         held64 = 1'b0;
  logic [127:0] hp64;
  logic [3:0]   ht64;
  always @(negedge clock) begin
    #1;
    if (!reset_n) begin
      held64 = 1'b0;
    end else begin
      if (held64 && out_valid64) begin
        check("hold_p64", p64, hp64);
        check("hold_tag64", 128'(out_tag64), 128'(ht64));
      end
      if (out_valid64 && out_ready64) begin
        if (q64_p.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected64: got p=0x%0h with no result expected", p64);
        end else begin
          check("p64", p64, q64_p.pop_front());
          check("tag64", 128'(out_tag64), 128'(q64_t.pop_front()));
        end
      end
      held64 = out_valid64 && !out_ready64;
      hp64   = p64;
      ht64   = out_tag64;
    end
  end

  // Monitor for the 16-bit instance
  logic        held16 = 1'b0;
  logic [31:0] hp16;
  logic [3:0]  ht16;
  always @(negedge clock) begin
    #1;
    if (!reset_n) begin
      held16 = 1'b0;
    end else begin
      if (held16 && out_valid16) begin
        check("hold_p16", 128'(p16), 128'(hp16));
        check("hold_tag16", 128'(out_tag16), 128'(ht16));
      end
      if (out_valid16 && out_ready16) begin
        if (q16_p.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected16: got p=0x%0h with no result expected", p16);
        end else begin
          check("p16", 128'(p16), 128'(q16_p.pop_front()));
          check("tag16", 128'(out_tag16), 128'(q16_t.pop_front()));
        end
      end
      held16 = out_valid16 && !out_ready16;
      hp16   = p16;
      ht16   = out_tag16;
    end
  end

  // Present one op and hold it until accepted; returns right after the accepting edge
  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    int k;
    k = 0;
    @(negedge clock);
    in_valid64 = 1'b1;
    x64 = a;
    y64 = b;
    in_tag64 = t;
    #1;
    while (!in_ready64 && k < 64) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (in_ready64) begin
      q64_p.push_back(128'(a) * 128'(b));
      q64_t.push_back(t);
    end else begin
      check("accept_timeout64", 128'(in_ready64), 128'(1));
    end
    @(posedge clock);
  endtask

  task automatic drain64(input int limit);
    int k;
    k = 0;
    while ((q64_p.size() != 0 || busy64) && k < limit) begin
      @(negedge clock);
      #2;
      k++;
    end
    check("drain64", 128'(q64_p.size()), 128'(0));
  endtask

  function automatic logic [15:0] pick16();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h0000;
      1:       v = 16'hFFFF;
      2:       v = 16'h8000;
      default: v = 16'($urandom());
    endcase
    return v;
  endfunction

  initial begin
    int accepts;
    int sent;
    int cycles;
    logic pend;
    logic [127:0] big;

    reset_n = 1'b0;
    in_valid64 = 1'b0; x64 = '0; y64 = '0; in_tag64 = '0; out_ready64 = 1'b1;
    in_valid16 = 1'b0; x16 = '0; y16 = '0; in_tag16 = '0; out_ready16 = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_out_valid", 128'(out_valid64), 128'(0));
    check("rst_p", p64, 128'(0));
    check("rst_busy", 128'(busy64), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check("post_rst_in_ready", 128'(in_ready64), 128'(1));
    check("post_rst_busy", 128'(busy64), 128'(0));
    check("post_rst_out_valid", 128'(out_valid64), 128'(0));
    check("post_rst_p", p64, 128'(0));
    check("post_rst_out_valid16", 128'(out_valid16), 128'(0));

    // All-ones operands: 4-cycle latency, single-cycle result
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5);
    big = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      if (i == 1) in_valid64 = 1'b0;
      #1;
      check("latency_out_valid", 128'(out_valid64), 128'(i == 4));
      if (i == 4) begin
        check("max_p", p64, big);
        check("max_tag", 128'(out_tag64), 128'(5));
      end
    end

    // Back-to-back issue at full throughput
    for (int k = 1; k <= 4; k++) send64(64'(k), 64'h1_0000_0001, 4'(k - 1));
    @(negedge clock);
    in_valid64 = 1'b0;
    drain64(20);

    // Backpressure: only four ops fit while the output is blocked
    @(negedge clock);
    out_ready64 = 1'b0;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      in_valid64 = 1'b1;
      x64 = 64'h1234_5678_9ABC_DEF0 + 64'(i);
      y64 = 64'hFEDC_BA98_7654_3210 - 64'(i);
      in_tag64 = 4'(i + 8);
      #1;
      if (in_ready64) begin
        q64_p.push_back(128'(x64) * 128'(y64));
        q64_t.push_back(in_tag64);
        accepts++;
      end
    end
    @(negedge clock);
    in_valid64 = 1'b0;
    #1;
    check("bp_accepts", 128'(accepts), 128'(4));
    check("bp_in_ready", 128'(in_ready64), 128'(0));
    check("bp_busy", 128'(busy64), 128'(1));
    check("bp_out_valid", 128'(out_valid64), 128'(1));
    @(negedge clock);
    out_ready64 = 1'b1;
    drain64(20);

    // Reset with two ops in flight: nothing may emerge afterwards
    send64(64'hDEAD_BEEF, 64'h0BAD_F00D, 4'd1);
    send64(64'hCAFE_BABE, 64'h1234_5678, 4'd2);
    @(negedge clock);
    in_valid64 = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid64), 128'(0));
    check("midrst_busy", 128'(busy64), 128'(0));
    check("midrst_p", p64, 128'(0));
    q64_p.delete();
    q64_t.delete();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      #1;
      check("after_rst_out_valid", 128'(out_valid64), 128'(0));
    end

    // Randomized traffic on the 16-bit instance with 50% output backpressure
    sent = 0;
    cycles = 0;
    pend = 1'b0;
    while (sent < 2000 && cycles < 20000) begin
      @(negedge clock);
      cycles++;
      out_ready16 = 1'($urandom_range(0, 1));
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        x16 = pick16();
        y16 = pick16();
        in_tag16 = 4'($urandom());
      end
      in_valid16 = pend;
      #1;
      if (pend && in_ready16) begin
        q16_p.push_back(32'(x16) * 32'(y16));
        q16_t.push_back(in_tag16);
        pend = 1'b0;
        sent++;
      end
    end
    check("rand_sent", 128'(sent), 128'(2000));
    @(negedge clock);
    in_valid16 = 1'b0;
    cycles = 0;
    while ((q16_p.size() != 0 || busy16) && cycles < 400) begin
      @(negedge clock);
      out_ready16 = 1'($urandom_range(0, 1));
      #2;
      cycles++;
    end
    check("drain16", 128'(q16_p.size()), 128'(0));

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
